sar_adc_ctrl: RTL

- Digital successive-approximation controller: the measuring end of the analog source models.
- Drives a DAC code into the simulated analog netlist and reads back a single comparator bit.
- Converts a node voltage into a WIDTH-bit code.
- Sits between the analog devices (source, RC sample/hold, DAC, comparator) and digital consumers of the result.

---
 rtl/sar_pkg.sv | 26 ++
 rtl/sar_timer.sv | 29 ++
 rtl/sar_adc_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation ADC controller:
// state encoding, parameter limits and a counter-width helper.
package sar_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    typedef logic [1:0] sar_state_t;

    localparam sar_state_t ST_IDLE   = 2'd0;
    localparam sar_state_t ST_SAMPLE = 2'd1;
    localparam sar_state_t ST_CONV   = 2'd2;
    localparam sar_state_t ST_DONE   = 2'd3;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sar_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded interval.
module sar_timer
    import sar_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] count;

    // A load on the expiring cycle wins, so back-to-back intervals have no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == CW'(1));

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: tracks the input, then decides one code
// bit per SETTLE cycles, MSB first, from the comparator.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int SCW = cnt_width(SETTLE);
    localparam int PCW = cnt_width(SAMPLE_CYC);
    localparam int TCW = max_int(SCW, PCW);
    localparam int IW  = $clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("sar_adc_ctrl: WIDTH out of range");
        end
        if (SAMPLE_CYC < 1) begin : g_bad_sample
            $error("sar_adc_ctrl: SAMPLE_CYC must be >= 1");
        end
        if (SETTLE < 1) begin : g_bad_settle
            $error("sar_adc_ctrl: SETTLE must be >= 1");
        end
    endgenerate

    sar_state_t       state;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] decided;
    logic             timer_load;
    logic [TCW-1:0]   timer_val;
    logic             timer_expire;

    sar_timer #(
        .CW(TCW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .load_val(timer_val),
        .expire  (timer_expire)
    );

    // Trial code with the current bit kept or cleared by the comparator.
    always_comb begin
        decided = dac_code;
        if (!cmp) begin
            decided[bit_idx] = 1'b0;
        end
    end

    always_comb begin
        timer_load = 1'b0;
        timer_val  = TCW'(SAMPLE_CYC);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    timer_load = 1'b1;
                    timer_val  = TCW'(SAMPLE_CYC);
                end
            end
            ST_SAMPLE: begin
                if (timer_expire) begin
                    timer_load = 1'b1;
                    timer_val  = TCW'(SETTLE);
                end
            end
            ST_CONV: begin
                if (timer_expire && bit_idx != '0) begin
                    timer_load = 1'b1;
                    timer_val  = TCW'(SETTLE);
                end
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            dac_code <= '0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (timer_expire) begin
                        state    <= ST_CONV;
                        bit_idx  <= IW'(WIDTH - 1);
                        dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
                    end
                end
                ST_CONV: begin
                    // The comparator only matters on the final settle cycle of each bit.
                    if (timer_expire) begin
                        if (bit_idx == '0) begin
                            state    <= ST_DONE;
                            dac_code <= decided;
                            result   <= decided;
                        end else begin
                            dac_code <= decided | (WIDTH'(1) << (bit_idx - 1'b1));
                            bit_idx  <= bit_idx - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample = (state == ST_SAMPLE);
    assign busy   = (state != ST_IDLE);
    assign valid  = (state == ST_DONE);

endmodule
